// File: rtl/voice_sequencer.sv
// rtl/voice_sequencer.sv - per-sample key scan controller for the synthesizer data_path
// Walks every key slot once per sample request and tracks per-key envelope state from note events.
module voice_sequencer #(
    parameter int NUM_KEYS = 128
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SAMPLE_REQ,
    input  logic        AVL_WRITE,
    input  logic [6:0]  AVL_KEY,
    input  logic [6:0]  AVL_VEL,
    input  logic        ATT_OFF,
    input  logic        NOTE_END,
    input  logic [31:0] TONE,
    output logic [6:0]  KEY,
    output logic        LD_PHASE,
    output logic        LD_AMP,
    output logic        LD_TONE,
    output logic        LD_VEL,
    output logic        PHASE_MUX,
    output logic        TONE_MUX,
    output logic        AMP_SEL,
    output logic        NOTE_ON,
    output logic        ATT_ON,
    output logic [31:0] SAMPLE_OUT,
    output logic        SAMPLE_VALID,
    output logic        BUSY,
    output logic        OVERRUN
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_ACCUM, S_SKIP, S_OUTPUT
    } scan_t;

    typedef enum logic [1:0] {
        ENV_IDLE, ENV_ATTACK, ENV_DECSUS, ENV_RELEASE
    } env_t;

    localparam logic [6:0] LAST_KEY = 7'(NUM_KEYS - 1);

    scan_t               state_q, state_d;
    logic [6:0]          key_q, key_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;
    logic [31:0]         sample_q, sample_d;
    logic                valid_q, valid_d;

    env_t                env_q [NUM_KEYS];
    env_t                env_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] gate_q, gate_d;
    logic [NUM_KEYS-1:0] restart_q, restart_d;

    env_t                cur_env;
    logic                cur_restart;
    logic                cur_end;
    logic                avl_hits_cur;

    assign cur_env      = env_q[key_q];
    assign cur_restart  = restart_q[key_q];
    // A releasing slot whose amplitude ran out is cleared in the same ACCUM cycle.
    assign cur_end      = !cur_restart && (cur_env == ENV_RELEASE) && NOTE_END;
    assign avl_hits_cur = AVL_WRITE && (AVL_KEY == key_q);

    function automatic scan_t key_entry(input env_t e);
        return (e == ENV_IDLE) ? S_SKIP : S_FETCH;
    endfunction

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;

        if (SAMPLE_REQ && (state_q != S_IDLE)) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (SAMPLE_REQ || pending_q) begin
                    state_d   = S_CLEAR;
                    pending_d = 1'b0;
                end
            end
            S_CLEAR: begin
                key_d   = '0;
                state_d = key_entry(env_q[0]);
            end
            S_FETCH: begin
                state_d = S_ACCUM;
            end
            S_ACCUM, S_SKIP: begin
                if (key_q == LAST_KEY) begin
                    state_d = S_OUTPUT;
                end else begin
                    key_d   = key_q + 7'd1;
                    state_d = key_entry(env_q[key_q + 7'd1]);
                end
            end
            S_OUTPUT: begin
                sample_d = TONE;
                valid_d  = 1'b1;
                // A request queued during the scan starts the next one with no idle gap.
                if (pending_q || SAMPLE_REQ) begin
                    state_d   = S_CLEAR;
                    pending_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        LD_PHASE  = 1'b0;
        LD_AMP    = 1'b0;
        LD_TONE   = 1'b0;
        PHASE_MUX = 1'b0;
        TONE_MUX  = 1'b0;
        AMP_SEL   = 1'b0;
        NOTE_ON   = 1'b0;
        ATT_ON    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                LD_TONE = 1'b1;
            end
            S_ACCUM: begin
                LD_PHASE  = 1'b1;
                LD_AMP    = 1'b1;
                LD_TONE   = 1'b1;
                TONE_MUX  = 1'b1;
                PHASE_MUX = !cur_restart && !cur_end;
                AMP_SEL   = cur_restart || cur_end;
                ATT_ON    = (cur_env == ENV_ATTACK) && !cur_restart;
                NOTE_ON   = gate_q[key_q];
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        env_d     = env_q;
        gate_d    = gate_q;
        restart_d = restart_q;

        // The note event takes precedence over the scan's own update of the same slot.
        if ((state_q == S_ACCUM) && !avl_hits_cur) begin
            if (cur_restart) begin
                restart_d[key_q] = 1'b0;
            end else if ((cur_env == ENV_ATTACK) && ATT_OFF) begin
                env_d[key_q] = ENV_DECSUS;
            end else if (cur_end) begin
                env_d[key_q] = ENV_IDLE;
            end
        end

        if (AVL_WRITE) begin
            if (AVL_VEL != 7'd0) begin
                env_d[AVL_KEY]     = ENV_ATTACK;
                gate_d[AVL_KEY]    = 1'b1;
                restart_d[AVL_KEY] = 1'b1;
            end else begin
                gate_d[AVL_KEY] = 1'b0;
                if ((env_q[AVL_KEY] == ENV_ATTACK) || (env_q[AVL_KEY] == ENV_DECSUS)) begin
                    env_d[AVL_KEY] = ENV_RELEASE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            key_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            gate_q    <= '0;
            restart_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                env_q[i] <= ENV_IDLE;
            end
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            gate_q    <= gate_d;
            restart_q <= restart_d;
            env_q     <= env_d;
        end
    end

    assign KEY          = key_q;
    assign LD_VEL       = AVL_WRITE;
    assign SAMPLE_OUT   = sample_q;
    assign SAMPLE_VALID = valid_q;
    assign BUSY         = (state_q != S_IDLE);
    assign OVERRUN      = overrun_q;

endmodule

// File: tb/tb_voice_sequencer.sv
// tb/tb_voice_sequencer.sv - self-checking bench for voice_sequencer
// Directed scans, a note-event vector table and randomized scans against an envelope model.
module tb_voice_sequencer;

    localparam int NK    = 128;
    localparam int E_IDLE = 0;
    localparam int E_ATT  = 1;
    localparam int E_DEC  = 2;
    localparam int E_REL  = 3;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        SAMPLE_REQ = 1'b0;
    logic        AVL_WRITE = 1'b0;
    logic [6:0]  AVL_KEY = '0;
    logic [6:0]  AVL_VEL = '0;
    logic        ATT_OFF = 1'b0;
    logic        NOTE_END = 1'b0;
    logic [31:0] TONE = '0;
    logic [6:0]  KEY;
    logic        LD_PHASE, LD_AMP, LD_TONE, LD_VEL;
    logic        PHASE_MUX, TONE_MUX, AMP_SEL, NOTE_ON, ATT_ON;
    logic [31:0] SAMPLE_OUT;
    logic        SAMPLE_VALID, BUSY, OVERRUN;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit tone_rand = 1'b0;

    int          m_env [NK];
    bit          m_gate [NK];
    bit          m_rst [NK];
    logic [3:0]  last_acc [NK];
    logic [31:0] tone_prev = '0;
    bit          in_scan = 1'b0;
    int          scan_cyc = 0;
    int          scan_exp = 0;
    int          mk;
    bit          e_pm, e_as, e_att, e_on;

    wire [50:0] all_outs = {KEY, LD_PHASE, LD_AMP, LD_TONE, LD_VEL, PHASE_MUX, TONE_MUX,
                            AMP_SEL, NOTE_ON, ATT_ON, SAMPLE_OUT, SAMPLE_VALID, BUSY, OVERRUN};

    typedef struct {
        logic [6:0] key;
        logic [6:0] vel;
        int         exp_len;
    } vec_t;
    vec_t vecs [8];

    voice_sequencer #(.NUM_KEYS(NK)) dut (
        .CLK(CLK), .RESET(RESET), .SAMPLE_REQ(SAMPLE_REQ), .AVL_WRITE(AVL_WRITE),
        .AVL_KEY(AVL_KEY), .AVL_VEL(AVL_VEL), .ATT_OFF(ATT_OFF), .NOTE_END(NOTE_END),
        .TONE(TONE), .KEY(KEY), .LD_PHASE(LD_PHASE), .LD_AMP(LD_AMP), .LD_TONE(LD_TONE),
        .LD_VEL(LD_VEL), .PHASE_MUX(PHASE_MUX), .TONE_MUX(TONE_MUX), .AMP_SEL(AMP_SEL),
        .NOTE_ON(NOTE_ON), .ATT_ON(ATT_ON), .SAMPLE_OUT(SAMPLE_OUT),
        .SAMPLE_VALID(SAMPLE_VALID), .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        #1;
        TONE = tone_rand ? $urandom : 32'd0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int active_count();
        int n = 0;
        for (int i = 0; i < NK; i++) if (m_env[i] != E_IDLE) n++;
        return n;
    endfunction

    // Envelope model: predicts the ACCUM controls of every visited key and each scan's length.
    always @(negedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NK; i++) begin
                m_env[i] = E_IDLE; m_gate[i] = 1'b0; m_rst[i] = 1'b0;
            end
            in_scan = 1'b0;
        end else begin
            chk("ld_vel", LD_VEL, AVL_WRITE);
            if (SAMPLE_VALID) begin
                chk("sample_out", SAMPLE_OUT, tone_prev);
                if (in_scan) chk("scan_len", scan_cyc, scan_exp);
                in_scan = 1'b0;
            end
            if (LD_TONE && !TONE_MUX) begin
                in_scan  = 1'b1;
                scan_cyc = 1;
                scan_exp = NK + 2 + active_count();
            end else if (in_scan) begin
                scan_cyc++;
            end
            if (LD_PHASE) begin
                mk    = int'(KEY);
                e_pm  = !m_rst[mk];
                e_as  = m_rst[mk];
                e_att = (m_env[mk] == E_ATT) && !m_rst[mk];
                e_on  = m_gate[mk];
                if (!m_rst[mk] && m_env[mk] == E_REL && NOTE_END) begin
                    e_pm = 1'b0; e_as = 1'b1;
                end
                chk("accum_active", m_env[mk] != E_IDLE, 1);
                chk("accum_ctrl", {LD_AMP, LD_TONE, TONE_MUX, PHASE_MUX, AMP_SEL, ATT_ON, NOTE_ON},
                    {3'b111, e_pm, e_as, e_att, e_on});
                last_acc[mk] = {PHASE_MUX, AMP_SEL, ATT_ON, NOTE_ON};
                if (!(AVL_WRITE && AVL_KEY == KEY)) begin
                    if (m_rst[mk]) m_rst[mk] = 1'b0;
                    else if (m_env[mk] == E_ATT && ATT_OFF) m_env[mk] = E_DEC;
                    else if (m_env[mk] == E_REL && NOTE_END) m_env[mk] = E_IDLE;
                end
            end
            if (AVL_WRITE) begin
                mk = int'(AVL_KEY);
                if (AVL_VEL != 0) begin
                    m_env[mk] = E_ATT; m_gate[mk] = 1'b1; m_rst[mk] = 1'b1;
                end else begin
                    m_gate[mk] = 1'b0;
                    if (m_env[mk] == E_ATT || m_env[mk] == E_DEC) m_env[mk] = E_REL;
                end
            end
        end
        tone_prev = TONE;
    end

    task automatic do_reset();
        @(posedge CLK); #1 RESET = 1'b1;
        @(posedge CLK); #1 RESET = 1'b0;
    endtask

    task automatic avl(input logic [6:0] k, input logic [6:0] v);
        @(posedge CLK); #1 AVL_WRITE = 1'b1; AVL_KEY = k; AVL_VEL = v;
        @(posedge CLK); #1 AVL_WRITE = 1'b0;
    endtask

    task automatic pulse_req();
        @(posedge CLK); #1 SAMPLE_REQ = 1'b1;
        @(posedge CLK); #1 SAMPLE_REQ = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        bit got = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge CLK);
            if (SAMPLE_VALID) got = 1'b1;
        end
        chk(nm, got, 1);
    endtask

    task automatic run_scan(input string nm, input int exp_len);
        int busy_n = 0;
        int ldp_n = 0;
        int clr_n = 0;
        bit got = 1'b0;
        pulse_req();
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge CLK);
            if (SAMPLE_VALID) got = 1'b1;
            else begin
                if (BUSY) busy_n++;
                if (LD_PHASE) ldp_n++;
                if (LD_TONE && !TONE_MUX) clr_n++;
            end
        end
        chk({nm, "_done"}, got, 1);
        chk({nm, "_len"}, busy_n, exp_len);
        chk({nm, "_clear"}, clr_n, 1);
        chk({nm, "_accums"}, ldp_n, exp_len - (NK + 2));
    endtask

    initial begin
        int t0;
        int sv_n;
        bit got;

        vecs[0] = '{7'd10,  7'd50, 131};
        vecs[1] = '{7'd20,  7'd1,  132};
        vecs[2] = '{7'd10,  7'd0,  132};
        vecs[3] = '{7'd10,  7'd0,  132};
        vecs[4] = '{7'd30,  7'd0,  132};
        vecs[5] = '{7'd20,  7'd70, 132};
        vecs[6] = '{7'd127, 7'd5,  133};
        vecs[7] = '{7'd0,   7'd9,  134};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_outputs", all_outs, 0);
        @(posedge CLK); #1 RESET = 1'b0;
        @(negedge CLK);
        chk("idle_outputs", all_outs, 0);

        run_scan("empty", 130);
        chk("empty_sample", SAMPLE_OUT, 0);
        tone_rand = 1'b1;

        avl(7'd60, 7'd100);
        last_acc[60] = 4'hF;
        run_scan("k60_first", 131);
        chk("k60_first_acc", last_acc[60], 4'b0101);
        run_scan("k60_second", 131);
        chk("k60_second_acc", last_acc[60], 4'b1011);
        #1 ATT_OFF = 1'b1;
        run_scan("k60_attoff", 131);
        chk("k60_attoff_acc", last_acc[60], 4'b1011);
        #1 ATT_OFF = 1'b0;
        run_scan("k60_decsus", 131);
        chk("k60_decsus_acc", last_acc[60], 4'b1001);
        avl(7'd60, 7'd0);
        run_scan("k60_rel", 131);
        chk("k60_rel_acc", last_acc[60], 4'b1000);
        #1 NOTE_END = 1'b1;
        run_scan("k60_end", 131);
        chk("k60_end_acc", last_acc[60], 4'b0100);
        #1 NOTE_END = 1'b0;
        run_scan("k60_gone", 130);

        avl(7'd5, 7'd40);
        run_scan("k5_on", 131);
        avl(7'd5, 7'd0);
        run_scan("k5_rel", 131);
        #1 NOTE_END = 1'b1;
        pulse_req();
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge CLK);
            if (BUSY && KEY == 7'd5) got = 1'b1;
        end
        chk("k5_fetch_seen", got, 1);
        @(posedge CLK); #1 AVL_WRITE = 1'b1; AVL_KEY = 7'd5; AVL_VEL = 7'd33;
        @(negedge CLK);
        chk("k5_same_cycle", {LD_PHASE, KEY}, {1'b1, 7'd5});
        @(posedge CLK); #1 AVL_WRITE = 1'b0;
        wait_valid("k5_collide_done");
        #1 NOTE_END = 1'b0;
        last_acc[5] = 4'hF;
        run_scan("k5_after", 131);
        chk("k5_after_acc", last_acc[5], 4'b0101);

        do_reset();
        for (int v = 0; v < 8; v++) begin
            avl(vecs[v].key, vecs[v].vel);
            run_scan($sformatf("vec%0d", v), vecs[v].exp_len);
        end

        for (int s = 0; s < 16; s++) begin
            repeat ($urandom_range(1, 4)) begin
                avl(7'($urandom_range(0, 7) * 17), ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom_range(1, 127)));
            end
            pulse_req();
            got = 1'b0;
            for (int c = 0; c < 400 && !got; c++) begin
                @(negedge CLK);
                if (SAMPLE_VALID) got = 1'b1;
                else begin
                    @(posedge CLK);
                    #1 ATT_OFF = 1'($urandom_range(0, 1));
                    NOTE_END = 1'($urandom_range(0, 1));
                end
            end
            chk("rand_done", got, 1);
        end
        #1 ATT_OFF = 1'b0; NOTE_END = 1'b0;

        for (int i = 0; i < NK; i++) avl(7'(i), 7'd64);
        pulse_req();
        t0 = cyc;
        repeat (50) @(posedge CLK);
        pulse_req();
        @(negedge CLK);
        chk("pending_no_overrun", OVERRUN, 0);
        repeat (20) @(posedge CLK);
        pulse_req();
        @(negedge CLK);
        chk("overrun_set", OVERRUN, 1);
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge CLK);
            if (SAMPLE_VALID) got = 1'b1;
        end
        chk("all_keys_done", got, 1);
        chk("all_keys_len", cyc - t0, 258);
        chk("b2b_clear", {BUSY, LD_TONE, TONE_MUX}, 3'b110);
        wait_valid("b2b_second_done");
        chk("b2b_idle_after", BUSY, 0);
        chk("overrun_held", OVERRUN, 1);
        do_reset();
        @(negedge CLK);
        chk("overrun_cleared", all_outs, 0);
        run_scan("post_reset", 130);

        avl(7'd9, 7'd77);
        pulse_req();
        repeat (40) @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK); #1 RESET = 1'b0;
        sv_n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            if (SAMPLE_VALID || BUSY) sv_n++;
        end
        chk("abort_no_valid", sv_n, 0);
        run_scan("abort_idle_keys", 130);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
